// File: rtl/pc_ir.sv
// Program counter and instruction register for the multi-cycle CPU fetch stage.
// One-cycle PC-to-IR latency; no backpressure, the control unit owns all sequencing.
module pc_ir #(
  parameter int unsigned          PC_W   = 16,
  parameter logic [PC_W-1:0]      RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            il_in,
  input  logic [1:0]      ps_in,
  input  logic [15:0]     imem_rdata_in,
  input  logic [PC_W-1:0] ra_in,
  output logic [PC_W-1:0] pc_out,
  output logic [15:0]     ins_out,
  output logic [31:0]     fetch_cnt_out,
  output logic [15:0]     br_cnt_out
);

  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_BR   = 2'b10,
    PS_JMP  = 2'b11
  } ps_e;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_nxt;
  logic [15:0]     ir_q;
  logic [31:0]     fetch_cnt_q;
  logic [15:0]     br_cnt_q;
  logic [5:0]      off6;
  logic [PC_W-1:0] br_off;
  ps_e             ps_sel;

  assign ps_sel = ps_e'(ps_in);

  // Branch offset always comes from the registered IR, so a same-edge IR load
  // cannot affect the target.
  assign off6   = {ir_q[8:6], ir_q[2:0]};
  assign br_off = {{(PC_W-6){off6[5]}}, off6};

  always_comb begin
    pc_nxt = pc_q;
    unique case (ps_sel)
      PS_HOLD: pc_nxt = pc_q;
      PS_INC:  pc_nxt = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      PS_BR:   pc_nxt = pc_q + br_off;
      PS_JMP:  pc_nxt = ra_in;
      default: pc_nxt = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RST_PC;
    end else begin
      pc_q <= pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= 16'h0000;
    end else if (il_in) begin
      ir_q <= imem_rdata_in;
    end
  end

  // Debug counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      br_cnt_q    <= '0;
    end else begin
      if (il_in && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if ((ps_sel == PS_BR) && (br_cnt_q != 16'hFFFF)) begin
        br_cnt_q <= br_cnt_q + 16'd1;
      end
    end
  end

  assign pc_out        = pc_q;
  assign ins_out       = ir_q;
  assign fetch_cnt_out = fetch_cnt_q;
  assign br_cnt_out    = br_cnt_q;

endmodule

// File: tb/tb_pc_ir.sv
// Bench for pc_ir: directed fetch/branch/jump/halt/reset/saturation sequences,
// checked every cycle against an arithmetic reference model plus literal pins.
module tb_pc_ir;

  logic        clk;
  logic        rst_n;
  logic        il;
  logic [1:0]  ps;
  logic [15:0] imem_rdata;
  logic [15:0] ra;
  logic [15:0] pc;
  logic [15:0] ins;
  logic [31:0] fetch_cnt;
  logic [15:0] br_cnt;

  logic [15:0] mem [0:65535];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  longint      m_fetch;
  longint      m_br;

  pc_ir #(.PC_W(16), .RST_PC(16'h0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .il_in         (il),
    .ps_in         (ps),
    .imem_rdata_in (imem_rdata),
    .ra_in         (ra),
    .pc_out        (pc),
    .ins_out       (ins),
    .fetch_cnt_out (fetch_cnt),
    .br_cnt_out    (br_cnt)
  );

  assign imem_rdata = mem[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: next state from the rules, 6-bit offset sign-extended as an integer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 16'h0000; m_ir = 16'h0000; m_fetch = 0; m_br = 0;
    end else begin
      logic [15:0] old_ir;
      logic signed [5:0] off;
      int step;
      old_ir = m_ir;
      if (il) begin
        m_ir = mem[m_pc];
        if (m_fetch < 64'hFFFF_FFFF) m_fetch = m_fetch + 1;
      end
      off  = {old_ir[8:6], old_ir[2:0]};
      step = off;
      case (ps)
        2'b01: m_pc = 16'((int'(m_pc) + 1) % 65536);
        2'b10: m_pc = 16'((int'(m_pc) + step + 65536) % 65536);
        2'b11: m_pc = ra;
        default: ;
      endcase
      if (ps == 2'b10 && m_br < 65535) m_br = m_br + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("pc_model", {16'h0, pc}, {16'h0, m_pc});
      chk("ins_model", {16'h0, ins}, {16'h0, m_ir});
      chk("fetch_model", fetch_cnt, m_fetch[31:0]);
      chk("br_model", {16'h0, br_cnt}, m_br[31:0]);
    end
  end

  task automatic step(input logic i, input logic [1:0] p, input logic [15:0] r);
    il = i; ps = p; ra = r;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503 + 7);
    mem[16'h0000] = 16'h1234;
    mem[16'h0001] = 16'h5678;
    mem[16'h0010] = 16'h01C6;
    mem[16'hFFFE] = 16'h0003;

    rst_n = 1'b0; il = 1'b0; ps = 2'b00; ra = 16'h0000;
    #3;
    chk("rst_pc", {16'h0, pc}, 32'h0);
    chk("rst_ins", {16'h0, ins}, 32'h0);
    chk("rst_fetch", fetch_cnt, 32'h0);
    chk("rst_br", {16'h0, br_cnt}, 32'h0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Sequential fetch
    step(1'b1, 2'b00, 16'h0);
    chk("seq_ins0", {16'h0, ins}, 32'h1234);
    chk("seq_pc0", {16'h0, pc}, 32'h0000);
    step(1'b0, 2'b01, 16'h0);
    chk("seq_pc1", {16'h0, pc}, 32'h0001);
    step(1'b1, 2'b00, 16'h0);
    chk("seq_ins1", {16'h0, ins}, 32'h5678);
    chk("seq_fetch", fetch_cnt, 32'd2);
    step(1'b0, 2'b01, 16'h0);
    chk("seq_pc2", {16'h0, pc}, 32'h0002);

    // Backward branch by -2
    step(1'b0, 2'b11, 16'h0010);
    step(1'b1, 2'b00, 16'h0);
    chk("bk_ins", {16'h0, ins}, 32'h01C6);
    step(1'b0, 2'b10, 16'h0);
    chk("bk_pc", {16'h0, pc}, 32'h000E);
    chk("bk_br", {16'h0, br_cnt}, 32'd1);

    // Forward branch wrapping past FFFF
    step(1'b0, 2'b11, 16'hFFFE);
    step(1'b1, 2'b00, 16'h0);
    step(1'b0, 2'b10, 16'h0);
    chk("fw_pc", {16'h0, pc}, 32'h0001);

    // Jump, then increment wrap
    step(1'b0, 2'b11, 16'hABCD);
    chk("jmp_pc", {16'h0, pc}, 32'hABCD);
    step(1'b0, 2'b11, 16'hFFFF);
    step(1'b0, 2'b01, 16'h0);
    chk("inc_wrap", {16'h0, pc}, 32'h0000);

    // Load and branch on the same edge: offset from old IR (0003)
    step(1'b1, 2'b10, 16'h0);
    chk("sim_ins", {16'h0, ins}, 32'h1234);
    chk("sim_pc", {16'h0, pc}, 32'h0003);

    // Halt
    step(1'b0, 2'b11, 16'h0123);
    for (int k = 0; k < 10; k++) step(1'b0, 2'b00, 16'h0);
    chk("halt_pc", {16'h0, pc}, 32'h0123);
    chk("halt_ins", {16'h0, ins}, 32'h1234);
    chk("halt_fetch", fetch_cnt, 32'd5);
    chk("halt_br", {16'h0, br_cnt}, 32'd3);

    // Async reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", {16'h0, pc}, 32'h0);
    chk("arst_ins", {16'h0, ins}, 32'h0);
    chk("arst_fetch", fetch_cnt, 32'h0);
    chk("arst_br", {16'h0, br_cnt}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 2'b00, 16'h0);
    chk("post_rst_ins", {16'h0, ins}, 32'h1234);

    // Branch counter saturation (IR offset of 1234 is +4)
    for (int k = 0; k < 65535; k++) step(1'b0, 2'b10, 16'h0);
    chk("sat_br_max", {16'h0, br_cnt}, 32'hFFFF);
    for (int k = 0; k < 3; k++) step(1'b0, 2'b10, 16'h0);
    chk("sat_br_hold", {16'h0, br_cnt}, 32'hFFFF);
    chk("sat_pc", {16'h0, pc}, 32'h0004 * 32'd65538 % 32'd65536);

    il = 1'b0; ps = 2'b00;
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
